// File: rtl/pcoeff_pkg.sv
// Shared definitions for the per-top pcoeff result accumulator: lane field
// layout, record type, FSM states and a saturating counter helper.
package pcoeff_pkg;

    localparam int unsigned LANE_W     = 64;
    localparam int unsigned ECC_BIT    = 63;
    localparam int unsigned COUNT_LSB  = 48;
    localparam int unsigned COUNT_W_IN = 13;
    localparam int unsigned SUM_W_IN   = 48;

    localparam int unsigned REC_SUM_W   = 64;
    localparam int unsigned REC_COUNT_W = 32;
    localparam int unsigned REC_CYC_W   = 32;

    typedef struct packed {
        logic [REC_SUM_W-1:0]   sum;
        logic [REC_COUNT_W-1:0] count;
        logic [REC_CYC_W-1:0]   bots;
        logic [REC_CYC_W-1:0]   beats;
        logic [REC_CYC_W-1:0]   cycles;
        logic                   ecc;
    } top_record_t;

    typedef enum logic {
        IDLE,
        IN_TOP
    } top_state_t;

    // Counters up to 64 bits wide pass through this, capped at max_value.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input logic [63:0] max_value);
        return (value == max_value) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/pcoeff_top_accumulator_fifo.sv
// First-word-fall-through record FIFO with occupancy count; head is the
// oldest stored record, a push becomes visible the cycle after it is written.
module top_record_fifo
    import pcoeff_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type rec_t = top_record_t
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       push,
    input  rec_t                       push_data,
    input  logic                       pop,
    output rec_t                       head,
    output logic                       not_empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    rec_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign not_empty = (count != '0);
    assign push_ok   = push && (count != CW'(DEPTH));
    assign pop_ok    = pop && not_empty;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/pcoeff_top_accumulator.sv
// Reduces the multi-lane bot result stream into one record per top (sum,
// pcoeff count, bots, beats, cycles, ecc) and buffers records for the host.
module pcoeff_top_accumulator
    import pcoeff_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned SUM_W      = 64,
    parameter int unsigned COUNT_W    = 32,
    parameter int unsigned CYC_W      = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          ivalid,
    output logic                          oready,
    input  logic [LANE_W*NUM_LANES-1:0]   results,
    input  logic [NUM_LANES-1:0]          lane_valid,
    input  logic                          last_of_top,
    output logic                          ovalid,
    input  logic                          iready,
    output logic [SUM_W-1:0]              rec_sum,
    output logic [COUNT_W-1:0]            rec_count,
    output logic [CYC_W-1:0]              rec_bots,
    output logic [CYC_W-1:0]              rec_beats,
    output logic [CYC_W-1:0]              rec_cycles,
    output logic                          rec_ecc
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;
    localparam logic [CYC_W-1:0] CYC_MAX = '1;

    typedef struct packed {
        logic [SUM_W-1:0]   sum;
        logic [COUNT_W-1:0] count;
        logic [CYC_W-1:0]   bots;
        logic [CYC_W-1:0]   beats;
        logic [CYC_W-1:0]   cycles;
        logic               ecc;
    } top_rec_t;

    function automatic logic [CYC_W-1:0] inc_sat(input logic [CYC_W-1:0] v);
        return CYC_W'(sat_inc(64'(v), 64'(CYC_MAX)));
    endfunction

    top_state_t          state, state_next;
    logic                ready_q;
    logic                accept;
    logic [CYC_W-1:0]    run_beats, run_cycles;
    logic [CYC_W-1:0]    beat_beats, beat_cycles;

    logic [SUM_W-1:0]    lane_sum;
    logic [COUNT_W-1:0]  lane_count;
    logic [CYC_W-1:0]    lane_bots;
    logic                lane_ecc;
    logic                unused_lane_bits;

    logic                s1_valid, s1_last, s1_ecc;
    logic [SUM_W-1:0]    s1_sum;
    logic [COUNT_W-1:0]  s1_count;
    logic [CYC_W-1:0]    s1_bots, s1_beats, s1_cycles;

    logic [SUM_W-1:0]    acc_sum, tot_sum;
    logic [COUNT_W-1:0]  acc_count, tot_count;
    logic [CYC_W-1:0]    acc_bots, tot_bots;
    logic [CYC_W:0]      bots_wide;
    logic                acc_ecc, tot_ecc;
    logic                s2_push;
    top_rec_t            s2_rec;

    top_rec_t            head;
    logic                not_empty;
    logic                pop;
    logic [CW-1:0]       fifo_count;
    logic [OW-1:0]       outstanding;

    assign oready = ready_q;
    assign accept = ivalid && ready_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        beat_beats  = CYC_W'(1);
        beat_cycles = CYC_W'(1);
        case (state)
            IDLE: begin
                if (accept && !last_of_top) state_next = IN_TOP;
            end
            IN_TOP: begin
                beat_beats  = inc_sat(run_beats);
                beat_cycles = inc_sat(run_cycles);
                if (accept && last_of_top) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The cycle counter runs every cycle of an open top, stalls included.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            run_beats  <= '0;
            run_cycles <= '0;
        end else if (state == IN_TOP) begin
            run_cycles <= beat_cycles;
            if (accept) run_beats <= beat_beats;
        end else if (accept) begin
            run_beats  <= CYC_W'(1);
            run_cycles <= CYC_W'(1);
        end
    end

    always_comb begin
        lane_sum   = '0;
        lane_count = '0;
        lane_bots  = '0;
        lane_ecc   = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (lane_valid[i]) begin
                lane_sum   = lane_sum + SUM_W'(results[LANE_W*i +: SUM_W_IN]);
                lane_count = lane_count + COUNT_W'(results[LANE_W*i + COUNT_LSB +: COUNT_W_IN]);
                lane_bots  = lane_bots + CYC_W'(1);
                lane_ecc   = lane_ecc | results[LANE_W*i + ECC_BIT];
            end
        end
    end

    always_comb begin
        unused_lane_bits = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            unused_lane_bits = unused_lane_bits ^ (^results[LANE_W*i + COUNT_LSB + COUNT_W_IN +: 2]);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_ecc    <= 1'b0;
            s1_sum    <= '0;
            s1_count  <= '0;
            s1_bots   <= '0;
            s1_beats  <= '0;
            s1_cycles <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_last   <= last_of_top;
                s1_ecc    <= lane_ecc;
                s1_sum    <= lane_sum;
                s1_count  <= lane_count;
                s1_bots   <= lane_bots;
                s1_beats  <= beat_beats;
                s1_cycles <= beat_cycles;
            end
        end
    end

    always_comb begin
        tot_sum   = acc_sum + s1_sum;
        tot_count = acc_count + s1_count;
        bots_wide = {1'b0, acc_bots} + {1'b0, s1_bots};
        tot_bots  = bots_wide[CYC_W] ? CYC_MAX : bots_wide[CYC_W-1:0];
        tot_ecc   = acc_ecc | s1_ecc;
    end

    // A last beat emits the finished record and reloads the accumulators in
    // the same cycle, so a following top starts without a bubble.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc_sum   <= '0;
            acc_count <= '0;
            acc_bots  <= '0;
            acc_ecc   <= 1'b0;
            s2_push   <= 1'b0;
            s2_rec    <= '0;
        end else begin
            s2_push <= s1_valid && s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    s2_rec.sum    <= tot_sum;
                    s2_rec.count  <= tot_count;
                    s2_rec.bots   <= tot_bots;
                    s2_rec.beats  <= s1_beats;
                    s2_rec.cycles <= s1_cycles;
                    s2_rec.ecc    <= tot_ecc;
                    acc_sum       <= '0;
                    acc_count     <= '0;
                    acc_bots      <= '0;
                    acc_ecc       <= 1'b0;
                end else begin
                    acc_sum   <= tot_sum;
                    acc_count <= tot_count;
                    acc_bots  <= tot_bots;
                    acc_ecc   <= tot_ecc;
                end
            end
        end
    end

    top_record_fifo #(
        .DEPTH (FIFO_DEPTH),
        .rec_t (top_rec_t)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (s2_push),
        .push_data (s2_rec),
        .pop       (pop),
        .head      (head),
        .not_empty (not_empty),
        .count     (fifo_count)
    );

    assign pop    = not_empty && iready;
    assign ovalid = not_empty;

    // Records owed after this edge: FIFO occupancy plus last beats still in
    // the two pipeline stages; one more accept must still fit.
    always_comb begin
        outstanding = OW'(fifo_count) + OW'(s2_push) - OW'(pop)
                    + OW'(accept && last_of_top) + OW'(s1_valid && s1_last);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (outstanding <= OW'(FIFO_DEPTH - 1));
        end
    end

    assign rec_sum    = head.sum;
    assign rec_count  = head.count;
    assign rec_bots   = head.bots;
    assign rec_beats  = head.beats;
    assign rec_cycles = head.cycles;
    assign rec_ecc    = head.ecc;

endmodule
